// File: rtl/giaima_rr_arbiter_pkg.sv
// Shared types and round-robin search for the giaima 8-way arbiter.
// Built with or without GIAIMA_RR_TIMEOUT_EN; nothing here depends on it.
package giaima_pkg;

    localparam int N_REQ = 8;

    typedef logic [2:0] idx_t;
    typedef logic [7:0] onehot_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    // First set bit strictly after ptr, wrapping; ptr itself is checked last.
    function automatic idx_t next_idx(onehot_t req, idx_t ptr);
        idx_t c;
        logic found;
        next_idx = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = ptr + 3'(k);
            if (!found && req[c]) begin
                next_idx = c;
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/giaima_rr_arbiter_38_en.sv
// 3-to-8 decoder with enable driving the shared select lines.
// Output is all-zero when EN is low, so it can never be multi-hot.
module giaima_38_en
    import giaima_pkg::*;
(
    input  idx_t    I,
    input  logic    EN,
    output onehot_t O
);

    always_comb begin
        O = '0;
        if (EN) O[I] = 1'b1;
    end

endmodule

// File: rtl/giaima_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with registered grant index.
// Define GIAIMA_RR_TIMEOUT_EN to enable the MAX_HOLD forced release.
module giaima_rr_arbiter
    import giaima_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int N_REQ    = 8
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  onehot_t REQ,
    input  logic    DONE,
    output onehot_t GNT,
    output idx_t    GNT_IDX,
    output logic    GNT_VLD,
    output logic    TIMEOUT
);

    if (N_REQ != giaima_pkg::N_REQ) begin : g_bad_nreq
        $error("N_REQ must be 8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 2..255");
    end

    state_t state, state_n;
    idx_t   gnt_idx, idx_n;
    idx_t   ptr, ptr_n;
    logic   gnt_vld, vld_n;
    logic   timeout, to_n;
    logic   hit;

`ifdef GIAIMA_RR_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturating so a long GRANT can never wrap back past HOLD_LAST.
    always_ff @(posedge CLK) begin
        if (!RST_N || state != GRANT) begin
            hold_cnt <= '0;
        end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hit = (state == GRANT) && (hold_cnt == HOLD_LAST);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        idx_n   = gnt_idx;
        vld_n   = gnt_vld;
        ptr_n   = ptr;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|REQ) begin
                    idx_n   = next_idx(REQ, ptr);
                    vld_n   = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (DONE || !REQ[gnt_idx] || hit) begin
                    vld_n   = 1'b0;
                    state_n = RELEASE;
                    to_n    = hit && !DONE;
                end
            end
            RELEASE: begin
                ptr_n   = gnt_idx;
                state_n = IDLE;
            end
            default: begin
                vld_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            gnt_idx <= 3'd7;
            ptr     <= 3'd7;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            gnt_idx <= idx_n;
            ptr     <= ptr_n;
            gnt_vld <= vld_n;
            timeout <= to_n;
        end
    end

    giaima_38_en u_dec (
        .I  (gnt_idx),
        .EN (gnt_vld),
        .O  (GNT)
    );

    assign GNT_IDX = gnt_idx;
    assign GNT_VLD = gnt_vld;
    assign TIMEOUT = timeout;

endmodule

// File: tb/tb_giaima_rr_arbiter.sv
// Scoreboard bench for giaima_rr_arbiter (MAX_HOLD=4).
// Timeout checks follow GIAIMA_RR_TIMEOUT_EN.
module tb_giaima_rr_arbiter;
    import giaima_pkg::*;

    logic    CLK = 1'b0;
    logic    RST_N;
    onehot_t REQ;
    logic    DONE;
    onehot_t GNT;
    idx_t    GNT_IDX;
    logic    GNT_VLD;
    logic    TIMEOUT;

    int n_tests = 0;
    int n_fail  = 0;
    idx_t exp_q[$];

    giaima_rr_arbiter #(.MAX_HOLD(4), .N_REQ(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_IDX (GNT_IDX),
        .GNT_VLD (GNT_VLD),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant(string tag);
        int c;
        idx_t e;
        c = 0;
        while (!GNT_VLD && c < 20) begin
            tick();
            c++;
        end
        chk({tag, "_wait"}, 32'(GNT_VLD), 32'd1);
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_idx"}, 32'(GNT_IDX), 32'(e));
            chk({tag, "_gnt"}, 32'(GNT), 32'(8'h01 << e));
        end
    endtask

    task automatic release_done(string tag);
        tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk({tag, "_gap"}, 32'(GNT), 32'd0);
        chk({tag, "_to"}, 32'(TIMEOUT), 32'd0);
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = 8'hFF;
        DONE  = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_vld", 32'(GNT_VLD), 32'd0);
        chk("rst_idx", 32'(GNT_IDX), 32'd7);
        chk("rst_to", 32'(TIMEOUT), 32'd0);

        exp_q.push_back(3'd0);
        RST_N = 1'b1;
        tick();
        chk("rst_first", 32'(GNT), 32'h01);
        wait_grant("first");

        for (int i = 1; i <= 8; i++) exp_q.push_back(idx_t'(i));
        for (int i = 1; i <= 8; i++) begin
            release_done("rot");
            wait_grant("rot");
        end
        release_done("rot_end");

        REQ = 8'h20;
        exp_q.push_back(3'd5);
        wait_grant("skip5");
        release_done("skip5");
        REQ = 8'b0000_1001;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd3);
        wait_grant("wrap0");
        release_done("wrap0");
        wait_grant("wrap3");
        release_done("wrap3");

        REQ = 8'h08;
        exp_q.push_back(3'd3);
        wait_grant("wd");
        REQ = 8'h00;
        tick();
        chk("wd_gnt", 32'(GNT), 32'd0);
        chk("wd_to", 32'(TIMEOUT), 32'd0);
        repeat (3) tick();
        chk("wd_idle", 32'(GNT_VLD), 32'd0);

        REQ = 8'h04;
        exp_q.push_back(3'd2);
        wait_grant("hold");
`ifdef GIAIMA_RR_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("tmo_held", 32'(GNT), 32'h04);
            chk("tmo_early", 32'(TIMEOUT), 32'd0);
        end
        tick();
        chk("tmo_drop", 32'(GNT), 32'd0);
        chk("tmo_pulse", 32'(TIMEOUT), 32'd1);
        tick();
        chk("tmo_idle", 32'(GNT), 32'd0);
        chk("tmo_once", 32'(TIMEOUT), 32'd0);
        tick();
        chk("tmo_regnt", 32'(GNT), 32'h04);
        repeat (3) tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk("both_gnt", 32'(GNT), 32'd0);
        chk("both_to", 32'(TIMEOUT), 32'd0);
`else
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("nto_held", 32'(GNT), 32'h04);
            chk("nto_to", 32'(TIMEOUT), 32'd0);
        end
        release_done("nto");
`endif

        REQ = 8'h10;
        exp_q.push_back(3'd4);
        wait_grant("mr");
        tick();
        chk("mr_pre", 32'(GNT), 32'h10);
        RST_N = 1'b0;
        tick();
        chk("mr_gnt", 32'(GNT), 32'd0);
        chk("mr_vld", 32'(GNT_VLD), 32'd0);
        chk("mr_idx", 32'(GNT_IDX), 32'd7);
        RST_N = 1'b1;
        REQ = 8'hFF;
        exp_q.push_back(3'd0);
        wait_grant("mr_after");
        release_done("mr_after");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
